// File: rtl/mac2x2_tile_seq.sv
// rtl/mac2x2_tile_seq.sv - sequences K operand beats through a 2x2 MAC array into one output tile; watchdog under MAC2X2_TILE_SEQ_WDOG_EN
module mac2x2_tile_seq #(
    parameter int KW       = 16,
    parameter int WDOG_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic signed [7:0]   op_a0,
    input  logic signed [7:0]   op_a1,
    input  logic signed [7:0]   op_b0,
    input  logic signed [7:0]   op_b1,
    output logic                arr_in_valid,
    output logic signed [7:0]   arr_a0,
    output logic signed [7:0]   arr_a1,
    output logic signed [7:0]   arr_b0,
    output logic signed [7:0]   arr_b1,
    output logic signed [31:0]  arr_acc00,
    output logic signed [31:0]  arr_acc01,
    output logic signed [31:0]  arr_acc10,
    output logic signed [31:0]  arr_acc11,
    input  logic                arr_out_valid,
    input  logic signed [31:0]  arr_y00,
    input  logic signed [31:0]  arr_y01,
    input  logic signed [31:0]  arr_y10,
    input  logic signed [31:0]  arr_y11,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [31:0]  res_y00,
    output logic signed [31:0]  res_y01,
    output logic signed [31:0]  res_y10,
    output logic signed [31:0]  res_y11
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_OP,
        S_WAIT_Y,
        S_RESULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [KW-1:0]      remain;
    logic signed [31:0] acc00;
    logic signed [31:0] acc01;
    logic signed [31:0] acc10;
    logic signed [31:0] acc11;

    logic start_fire;
    logic op_fire;
    logic y_fire;
    logic res_fire;
    logic wdog_fire;

`ifdef MAC2X2_TILE_SEQ_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);

    logic [WDW-1:0] wdog_cnt;

    // Timeout on the WDOG_CYC-th WAIT_Y cycle without a response; the partial sums drain as the result.
    assign wdog_fire = (state == S_WAIT_Y) && !arr_out_valid && (wdog_cnt == WDW'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (op_fire) begin
            wdog_cnt <= '0;
        end else if ((state == S_WAIT_Y) && !arr_out_valid) begin
            wdog_cnt <= wdog_cnt + WDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start_fire) begin
            err <= 1'b0;
        end else if (wdog_fire) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_wdog_cyc;

    assign unused_wdog_cyc = ^WDOG_CYC;
    assign wdog_fire       = 1'b0;
    assign err             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        start_fire = 1'b0;
        op_fire    = 1'b0;
        y_fire     = 1'b0;
        res_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_fire = 1'b1;
                    state_nxt  = (k_len != '0) ? S_WAIT_OP : S_RESULT;
                end
            end
            S_WAIT_OP: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_fire   = 1'b1;
                    state_nxt = S_WAIT_Y;
                end
            end
            S_WAIT_Y: begin
                if (arr_out_valid) begin
                    y_fire    = 1'b1;
                    state_nxt = (remain == KW'(1)) ? S_RESULT : S_WAIT_OP;
                end else if (wdog_fire) begin
                    state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain       <= '0;
            acc00        <= '0;
            acc01        <= '0;
            acc10        <= '0;
            acc11        <= '0;
            arr_a0       <= '0;
            arr_a1       <= '0;
            arr_b0       <= '0;
            arr_b1       <= '0;
            arr_in_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            arr_in_valid <= op_fire;
            done         <= res_fire;
            if (start_fire) begin
                remain <= k_len;
                acc00  <= '0;
                acc01  <= '0;
                acc10  <= '0;
                acc11  <= '0;
            end
            if (op_fire) begin
                arr_a0 <= op_a0;
                arr_a1 <= op_a1;
                arr_b0 <= op_b0;
                arr_b1 <= op_b1;
            end
            if (y_fire) begin
                acc00  <= arr_y00;
                acc01  <= arr_y01;
                acc10  <= arr_y10;
                acc11  <= arr_y11;
                remain <= remain - KW'(1);
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign arr_acc00 = acc00;
    assign arr_acc01 = acc01;
    assign arr_acc10 = acc10;
    assign arr_acc11 = acc11;
    assign res_y00   = acc00;
    assign res_y01   = acc01;
    assign res_y10   = acc10;
    assign res_y11   = acc11;

endmodule

// File: tb/tb_mac2x2_tile_seq.sv
// tb/tb_mac2x2_tile_seq.sv - scoreboard bench for mac2x2_tile_seq driving a behavioural 2x2 MAC array with random latency
`timescale 1ns/1ps
module tb_mac2x2_tile_seq;

    localparam int KW   = 16;
    localparam int WDOG = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy, done, err;
    logic          op_valid, op_ready;
    logic [7:0]    op_a0, op_a1, op_b0, op_b1;
    logic          arr_in_valid;
    logic [7:0]    arr_a0, arr_a1, arr_b0, arr_b1;
    logic [31:0]   arr_acc00, arr_acc01, arr_acc10, arr_acc11;
    logic          arr_out_valid;
    logic [31:0]   arr_y00, arr_y01, arr_y10, arr_y11;
    logic          res_valid, res_ready;
    logic [31:0]   res_y00, res_y01, res_y10, res_y11;

    mac2x2_tile_seq #(.KW(KW), .WDOG_CYC(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .err(err),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a0(op_a0), .op_a1(op_a1), .op_b0(op_b0), .op_b1(op_b1),
        .arr_in_valid(arr_in_valid),
        .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
        .arr_acc00(arr_acc00), .arr_acc01(arr_acc01), .arr_acc10(arr_acc10), .arr_acc11(arr_acc11),
        .arr_out_valid(arr_out_valid),
        .arr_y00(arr_y00), .arr_y01(arr_y01), .arr_y10(arr_y10), .arr_y11(arr_y11),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y00(res_y00), .res_y01(res_y01), .res_y10(res_y10), .res_y11(res_y11)
    );

    int tests = 0;
    int fails = 0;
    logic [159:0] beat_q[$];
    logic [127:0] res_q[$];
    logic [31:0]  tile_beats[$];
    int  rs[4];
    int  inv_cnt = 0;
    bit  hold_y = 1'b0;
    bit  kill = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] sums();
        return {rs[0], rs[1], rs[2], rs[3]};
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, op_ready, arr_in_valid, res_valid}, 0);
        check({tag, "_ops"}, {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
        check({tag, "_acc"}, {arr_acc00, arr_acc01, arr_acc10, arr_acc11}, 0);
        check({tag, "_res"}, {res_y00, res_y01, res_y10, res_y11}, 0);
    endtask

    // Behavioural array: y = acc + a*b per output, random 1..3 cycle latency; stray responses when nothing is pending.
    initial begin
        int cnt;
        bit pend;
        bit prev_inv;
        int y00, y01, y10, y11;
        logic [159:0] e;
        cnt = 0; pend = 0; prev_inv = 0;
        y00 = 0; y01 = 0; y10 = 0; y11 = 0;
        arr_out_valid = 0;
        {arr_y00, arr_y01, arr_y10, arr_y11} = '0;
        forever begin
            @(negedge clk);
            if (arr_in_valid) begin
                inv_cnt++;
                check("in_valid_single_cycle", prev_inv, 0);
                check("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    e = beat_q.pop_front();
                    check("beat_ops", {arr_a0, arr_a1, arr_b0, arr_b1}, e[159:128]);
                    check("beat_acc", {arr_acc00, arr_acc01, arr_acc10, arr_acc11}, e[127:0]);
                end
                y00 = $signed(arr_acc00) + $signed(arr_a0) * $signed(arr_b0);
                y01 = $signed(arr_acc01) + $signed(arr_a0) * $signed(arr_b1);
                y10 = $signed(arr_acc10) + $signed(arr_a1) * $signed(arr_b0);
                y11 = $signed(arr_acc11) + $signed(arr_a1) * $signed(arr_b1);
                pend = 1;
                cnt = $urandom_range(1, 3);
            end
            prev_inv = arr_in_valid;
            @(posedge clk); #1;
            arr_out_valid = 0;
            if (kill) pend = 0;
            if (pend && !hold_y) begin
                cnt--;
                if (cnt == 0) begin
                    arr_out_valid = 1;
                    {arr_y00, arr_y01, arr_y10, arr_y11} = {y00, y01, y10, y11};
                    pend = 0;
                end
            end else if (!pend && (!busy || op_ready || res_valid) && $urandom_range(0, 3) == 0) begin
                arr_out_valid = 1;
                {arr_y00, arr_y01, arr_y10, arr_y11} = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    initial begin
        bit done_exp;
        logic [127:0] e;
        done_exp = 0;
        forever begin
            @(negedge clk);
            if (done_exp) begin
                check("done_pulse", done, 1);
                check("busy_low_with_done", busy, 0);
            end else if (done) begin
                check("done_spurious", done, 0);
            end
            done_exp = 0;
            if (res_valid && res_ready) begin
                check("res_expected", res_q.size() != 0, 1);
                if (res_q.size() != 0) begin
                    e = res_q.pop_front();
                    check("res_tile", {res_y00, res_y01, res_y10, res_y11}, e);
                end
                done_exp = 1;
            end
        end
    end

    task automatic start_tile(input int k);
        @(posedge clk); #1;
        start = 1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 0;
        k_len = KW'($urandom);
        rs = '{0, 0, 0, 0};
        @(negedge clk);
        if (k == 0) check("zero_len_res_valid_next", res_valid, 1);
        else check("start_op_ready_next", op_ready, 1);
        check("err_clear_on_start", err, 0);
    endtask

    task automatic issue_beat(input logic [31:0] bt, input int gap);
        int n;
        int a0, a1, b0, b1;
        n = 0;
        a0 = $signed(bt[31:24]);
        a1 = $signed(bt[23:16]);
        b0 = $signed(bt[15:8]);
        b1 = $signed(bt[7:0]);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        beat_q.push_back({bt, sums()});
        op_valid = 1;
        {op_a0, op_a1, op_b0, op_b1} = bt;
        @(negedge clk);
        while (!op_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("op_handshake_wait", op_ready, 1);
        @(posedge clk); #1;
        op_valid = 0;
        {op_a0, op_a1, op_b0, op_b1} = $urandom;
        rs[0] += a0 * b0;
        rs[1] += a0 * b1;
        rs[2] += a1 * b0;
        rs[3] += a1 * b1;
    endtask

    task automatic finish_result(input logic [127:0] exp, input int resgap, input bit poke);
        int n;
        n = 0;
        res_q.push_back(exp);
        @(negedge clk);
        while (!res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_wait", res_valid, 1);
        for (int h = 0; h < resgap; h++) begin
            check("res_y_held", {res_y00, res_y01, res_y10, res_y11}, exp);
            @(posedge clk); #1;
            start = poke && (h == 0);
            k_len = KW'($urandom_range(1, 7));
            @(negedge clk);
        end
        check("res_valid_until_ready", res_valid, 1);
        @(posedge clk); #1;
        start = 0;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        @(negedge clk);
        check("idle_after_done", busy, 0);
    endtask

    task automatic run_tile(input int gap, input int resgap, input bit poke);
        int k;
        int inv0;
        k = tile_beats.size();
        inv0 = inv_cnt;
        start_tile(k);
        foreach (tile_beats[i]) issue_beat(tile_beats[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        finish_result(sums(), resgap, poke);
        check("in_valid_count", inv_cnt - inv0, k);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [127:0] snap;
        int n;
        int wy;
        rst_n = 0; start = 0; k_len = '0; op_valid = 0; res_ready = 0;
        {op_a0, op_a1, op_b0, op_b1} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1;

        tile_beats = {32'h03FE0405};
        run_tile(0, 0, 0);

        tile_beats = {32'h01020304, 32'hFF0102FE, 32'h7F800101};
        run_tile(0, 1, 0);

        tile_beats = {};
        run_tile(0, 1, 0);

        tile_beats = {$urandom, $urandom};
        run_tile(5, 4, 1);

        // Reset while step 2 of 3 is waiting on the array; its late response lands in IDLE.
        start_tile(3);
        issue_beat($urandom, 0);
        issue_beat($urandom, 0);
        hold_y = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check_zero_outputs("reset_mid_tile");
        hold_y = 0;
        repeat (6) @(negedge clk);
        check("late_y_ignored_acc", {arr_acc00, arr_acc01, arr_acc10, arr_acc11}, 0);
        check("late_y_ignored_idle", busy, 0);
        tile_beats = {$urandom, $urandom, $urandom};
        run_tile(-1, 1, 0);

        for (int t = 0; t < 10; t++) begin
            tile_beats = {};
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) tile_beats.push_back($urandom);
            run_tile(-1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef MAC2X2_TILE_SEQ_WDOG_EN
        start_tile(2);
        issue_beat($urandom, 0);
        snap = sums();
        issue_beat($urandom, 0);
        hold_y = 1;
        n = 0;
        wy = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            if (busy && !op_ready && !res_valid) wy++;
            n++;
        end
        check("wdog_wait_y_cycles", wy, WDOG);
        check("wdog_err_set", err, 1);
        finish_result(snap, 2, 0);
        check("wdog_err_sticky", err, 1);
        kill = 1;
        repeat (2) @(negedge clk);
        kill = 0;
        hold_y = 0;
        tile_beats = {$urandom, $urandom};
        run_tile(-1, 0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
